// File: rtl/kernel_prueba_stream_alu_pkg.sv
// Shared types and helpers for the per-lane streaming ALU.
// Imported by the lane, the top level and the bench.
package kernel_prueba_stream_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_RSUB = 3'd2,
    ALU_MUL  = 3'd3,
    ALU_MAX  = 3'd4,
    ALU_MIN  = 3'd5,
    ALU_PASS = 3'd6
  } alu_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } alu_state_t;

  function automatic int lane_count(
    input int data_w,
    input int lane_w
  );
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/kernel_prueba_stream_alu_if.sv
// AXI-stream style valid/ready bundle.
// master drives the beat, slave drives tready.
interface kernel_prueba_stream_alu_if #(
  parameter int DW = 512
);
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;

  modport master (
    output tvalid, tdata, tkeep, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast,
    output tready
  );
endinterface

// File: rtl/kernel_prueba_stream_alu_lane.sv
// One lane: unsigned op against the latched constant,
// with optional clamp on carry, borrow or multiply overflow.
module kernel_prueba_stream_alu_lane
  import kernel_prueba_stream_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] d,
  input  logic [W-1:0] k,
  input  logic [2:0]   mode,
  input  logic         sat,
  output logic [W-1:0] r
);

  logic [W:0]     add_w;
  logic [W:0]     sub_w;
  logic [W:0]     rsub_w;
  logic [2*W-1:0] mul_w;

  assign add_w  = {1'b0, d} + {1'b0, k};
  assign sub_w  = {1'b0, d} - {1'b0, k};
  assign rsub_w = {1'b0, k} - {1'b0, d};
  assign mul_w  = {{W{1'b0}}, d} * {{W{1'b0}}, k};

  always_comb begin
    r = d;
    unique case (mode)
      ALU_ADD:
        r = (sat && add_w[W]) ? '1 : add_w[W-1:0];
      ALU_SUB:
        r = (sat && sub_w[W]) ? '0 : sub_w[W-1:0];
      ALU_RSUB:
        r = (sat && rsub_w[W]) ? '0 : rsub_w[W-1:0];
      ALU_MUL:
        r = (sat && |mul_w[2*W-1:W]) ? '1
                                     : mul_w[W-1:0];
      ALU_MAX:
        r = (d > k) ? d : k;
      ALU_MIN:
        r = (d < k) ? d : k;
      default:
        r = d;
    endcase
  end

endmodule

// File: rtl/kernel_prueba_stream_alu.sv
// Streaming ALU top: run FSM, lane array, bubble-collapsing
// pipeline, tlast gating and output beat counter.
module kernel_prueba_stream_alu
  import kernel_prueba_stream_alu_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_LANE_WIDTH       = 32,
  parameter int C_PIPE_STAGES      = 2,
  parameter int C_COUNT_WIDTH      = 32
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     ctrl_start,
  input  logic [2:0]               ctrl_mode,
  input  logic                     ctrl_saturate,
  input  logic [C_LANE_WIDTH-1:0]  ctrl_constant,
  output logic                     ctrl_busy,
  output logic                     ctrl_done,
  output logic [C_COUNT_WIDTH-1:0] ctrl_beat_count,
  kernel_prueba_stream_alu_if.slave  s_axis,
  kernel_prueba_stream_alu_if.master m_axis
);

  localparam int DW = C_AXIS_TDATA_WIDTH;
  localparam int LW = C_LANE_WIDTH;
  localparam int KW = DW / 8;
  localparam int N  = C_PIPE_STAGES;
  localparam int CW = C_COUNT_WIDTH;
  localparam int LANES = lane_count(DW, LW);

  alu_state_t      state;
  logic [2:0]      mode_q;
  logic            sat_q;
  logic [LW-1:0]   k_q;
  logic            last_in;
  logic [CW-1:0]   count;

  logic [DW-1:0]   alu_res;
  logic [N-1:0]    v_q;
  logic [N-1:0]    last_q;
  logic [N-1:0]    load;
  logic [DW-1:0]   dat_q  [N];
  logic [KW-1:0]   keep_q [N];
  logic            stall_c;
  logic            s_fire;
  logic            m_fire;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    kernel_prueba_stream_alu_lane #(
      .W (LW)
    ) u_lane (
      .d    (s_axis.tdata[g*LW +: LW]),
      .k    (k_q),
      .mode (mode_q),
      .sat  (sat_q),
      .r    (alu_res[g*LW +: LW])
    );
  end

  // A stage stalls only if it and every stage after it hold data
  // and the sink refuses; anything else lets it load.
  always_comb begin
    stall_c = ~m_axis.tready;
    load    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      stall_c = stall_c & v_q[i];
      load[i] = ~stall_c;
    end
  end

  assign ctrl_busy       = (state == ST_RUN);
  assign s_axis.tready   = ctrl_busy & ~last_in & load[0];
  assign s_fire          = s_axis.tvalid & s_axis.tready;
  assign m_fire          = m_axis.tvalid & m_axis.tready;
  assign ctrl_done       = ctrl_busy & m_fire & m_axis.tlast;
  assign ctrl_beat_count = count;

  assign m_axis.tvalid = v_q[N-1];
  assign m_axis.tdata  = dat_q[N-1];
  assign m_axis.tkeep  = keep_q[N-1];
  assign m_axis.tlast  = last_q[N-1];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= ST_IDLE;
      mode_q  <= '0;
      sat_q   <= 1'b0;
      k_q     <= '0;
      last_in <= 1'b0;
      count   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ctrl_start) begin
            state   <= ST_RUN;
            mode_q  <= ctrl_mode;
            sat_q   <= ctrl_saturate;
            k_q     <= ctrl_constant;
            last_in <= 1'b0;
            count   <= '0;
          end
        end
        ST_RUN: begin
          if (s_fire && s_axis.tlast)
            last_in <= 1'b1;
          if (m_fire)
            count <= count + CW'(1);
          if (ctrl_done)
            state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      v_q    <= '0;
      last_q <= '0;
      for (int i = 0; i < N; i++) begin
        dat_q[i]  <= '0;
        keep_q[i] <= '0;
      end
    end else begin
      if (load[0])
        v_q[0] <= s_fire;
      if (s_fire) begin
        dat_q[0]  <= alu_res;
        keep_q[0] <= s_axis.tkeep;
        last_q[0] <= s_axis.tlast;
      end
      for (int i = 1; i < N; i++) begin
        if (load[i]) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) begin
            dat_q[i]  <= dat_q[i-1];
            keep_q[i] <= keep_q[i-1];
            last_q[i] <= last_q[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_prueba_stream_alu.sv
// Randomised bench for the streaming ALU with an
// arithmetic reference model of the lane operations.
module tb_kernel_prueba_stream_alu;
  import kernel_prueba_stream_alu_pkg::*;

  localparam int DW = 128;
  localparam int LW = 32;
  localparam int N  = 3;
  localparam int CW = 32;
  localparam int KW = DW / 8;
  localparam int L  = DW / LW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    mode = '0;
  logic          sat = 1'b0;
  logic [LW-1:0] kin = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  kernel_prueba_stream_alu_if #(.DW(DW)) s_if ();
  kernel_prueba_stream_alu_if #(.DW(DW)) m_if ();

  kernel_prueba_stream_alu #(
    .C_AXIS_TDATA_WIDTH (DW),
    .C_LANE_WIDTH       (LW),
    .C_PIPE_STAGES      (N),
    .C_COUNT_WIDTH      (CW)
  ) dut (
    .aclk            (clk),
    .areset_n        (rst_n),
    .ctrl_start      (start),
    .ctrl_mode       (mode),
    .ctrl_saturate   (sat),
    .ctrl_constant   (kin),
    .ctrl_busy       (busy),
    .ctrl_done       (done),
    .ctrl_beat_count (cnt),
    .s_axis          (s_if),
    .m_axis          (m_if)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] in_d [$];
  logic [KW-1:0] in_k [$];
  logic [DW-1:0] out_d [$];
  logic [KW-1:0] out_k [$];
  logic          out_l [$];
  int            acc_cyc [$];
  int            out_cyc [$];
  int            done_cnt;
  int            stall_viol;
  int            rdy_viol;
  bit            timed_out;

  function automatic logic [LW-1:0] ref_lane(
    input logic [LW-1:0] d,
    input logic [LW-1:0] k,
    input int            md,
    input bit            st
  );
    longint unsigned dd, kk, mx, r;
    dd = d;
    kk = k;
    mx = (64'd1 << LW) - 1;
    case (md)
      0: begin
        r = dd + kk;
        if (r > mx) r = st ? mx : r - (mx + 1);
      end
      1: r = (dd >= kk) ? dd - kk : (st ? 0 : dd + (mx + 1) - kk);
      2: r = (kk >= dd) ? kk - dd : (st ? 0 : kk + (mx + 1) - dd);
      3: begin
        r = dd * kk;
        if (r > mx) r = st ? mx : (r & mx);
      end
      4: r = (dd > kk) ? dd : kk;
      5: r = (dd < kk) ? dd : kk;
      default: r = dd;
    endcase
    return r[LW-1:0];
  endfunction

  function automatic logic [DW-1:0] ref_beat(
    input logic [DW-1:0] d,
    input int            md,
    input bit            st,
    input logic [LW-1:0] k
  );
    logic [DW-1:0] r;
    for (int l = 0; l < L; l++)
      r[l*LW +: LW] = ref_lane(d[l*LW +: LW], k, md, st);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int l = 0; l < L; l++)
      r[l*LW +: LW] = $urandom_range(1) ? LW'($urandom)
                                        : LW'($urandom_range(1000));
    return r;
  endfunction

  task automatic do_start(input int md, input bit st,
                          input logic [LW-1:0] kk);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = md[2:0];
    sat   = st;
    kin   = kk;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 3'($urandom_range(7));
    sat   = 1'($urandom_range(1));
    kin   = LW'($urandom);
  endtask

  task automatic run(input int abort_at, input int gap_pct,
                     input int rdy_pct, input int gap_at,
                     input int start_mid_at, input bit start_on_last);
    int idx = 0;
    int gap_left = 2;
    int cyc = 0;
    int n = in_d.size();
    bit fin = 0;
    bit pend = 0;
    bit last_seen = 0;
    bit prev_stall = 0;
    logic [DW-1:0] pd = '0;
    logic [KW-1:0] pk = '0;
    logic          pl = 1'b0;
    out_d.delete(); out_k.delete(); out_l.delete();
    acc_cyc.delete(); out_cyc.delete();
    done_cnt = 0; stall_viol = 0; rdy_viol = 0;
    while (!fin && idx < abort_at && cyc < 3000) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!pend) begin
        if (idx >= n) begin
          s_if.tvalid = 1'b0;
        end else if (idx == gap_at && gap_left > 0) begin
          gap_left--;
          s_if.tvalid = 1'b0;
        end else if ($urandom_range(99) < gap_pct) begin
          s_if.tvalid = 1'b0;
        end else begin
          s_if.tvalid = 1'b1;
          s_if.tdata  = in_d[idx];
          s_if.tkeep  = in_k[idx];
          s_if.tlast  = (idx == n - 1);
          pend = 1;
        end
      end
      m_if.tready = ($urandom_range(99) < rdy_pct);
      if (cyc == start_mid_at) begin
        start = 1'b1;
        mode  = 3'($urandom_range(7));
      end
      if (start_on_last && m_if.tvalid && m_if.tlast && m_if.tready) begin
        start = 1'b1;
        mode  = 3'($urandom_range(7));
      end
      @(negedge clk);
      if (last_seen && s_if.tready) rdy_viol++;
      if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== pd ||
                         m_if.tkeep !== pk || m_if.tlast !== pl))
        stall_viol++;
      prev_stall = m_if.tvalid && !m_if.tready;
      pd = m_if.tdata; pk = m_if.tkeep; pl = m_if.tlast;
      if (s_if.tvalid && s_if.tready) begin
        acc_cyc.push_back(cyc);
        if (s_if.tlast) last_seen = 1;
        idx++;
        pend = 0;
      end
      if (done) done_cnt++;
      if (m_if.tvalid && m_if.tready) begin
        out_d.push_back(m_if.tdata);
        out_k.push_back(m_if.tkeep);
        out_l.push_back(m_if.tlast);
        out_cyc.push_back(cyc);
        if (m_if.tlast) fin = 1;
      end
      cyc++;
    end
    timed_out = (cyc >= 3000);
  endtask

  task automatic fill(input int n);
    in_d.delete(); in_k.delete();
    for (int b = 0; b < n; b++) begin
      in_d.push_back(rand_beat());
      in_k.push_back(KW'($urandom));
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({m_if.tvalid, m_if.tlast, m_if.tkeep} !== '0) begin
      n_err++;
      $display("FAIL reset_m_ctrl: got %h want 0",
               {m_if.tvalid, m_if.tlast, m_if.tkeep});
    end
    n_vec++;
    if (m_if.tdata !== '0) begin
      n_err++;
      $display("FAIL reset_m_data: got %h want 0", m_if.tdata);
    end
    n_vec++;
    if ({busy, done, s_if.tready, cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %h want 0",
               {busy, done, s_if.tready, cnt});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, s_if.tready, m_if.tvalid} !== 3'b000) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b want 000",
               {busy, s_if.tready, m_if.tvalid});
    end
  endtask

  task automatic test_add_wrap_sat();
    logic [LW-1:0] lo, hi;
    for (int st = 0; st < 2; st++) begin
      in_d.delete(); in_k.delete();
      hi = 32'hFFFF_FFF8;
      lo = 32'h1;
      for (int b = 0; b < 4; b++) begin
        in_d.push_back((b % 2 == 0) ? {L{hi}} : {L{lo}});
        in_k.push_back(KW'($urandom));
      end
      do_start(ALU_ADD, st[0], 32'h10);
      run(99, 0, 100, -1, -1, 0);
      n_vec++;
      if (timed_out || out_d.size() != 4) begin
        n_err++;
        $display("FAIL add_count st=%0d: got %0d beats want 4", st, out_d.size());
      end
      for (int b = 0; b < out_d.size() && b < 4; b++) begin
        lo = (b % 2 == 0) ? (st ? 32'hFFFF_FFFF : 32'h8) : 32'h11;
        n_vec++;
        if (out_d[b] !== {L{lo}} || out_k[b] !== in_k[b] || out_l[b] !== (b == 3)) begin
          n_err++;
          $display("FAIL add st=%0d beat %0d: got %h/%h/%b want %h/%h/%b",
                   st, b, out_d[b], out_k[b], out_l[b], {L{lo}}, in_k[b], b == 3);
        end
      end
      @(negedge clk);
      n_vec++;
      if (done_cnt != 1 || cnt !== 32'd4 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL add_done st=%0d: got done=%0d cnt=%0d busy=%b want 1/4/0",
                 st, done_cnt, cnt, busy);
      end
    end
  endtask

  task automatic test_sub_mul_sat();
    int            md [3] = '{1, 3, 3};
    bit            st [3] = '{1, 1, 0};
    logic [LW-1:0] kk [3] = '{32'h5, 32'h10, 32'h10};
    logic [LW-1:0] dd [3] = '{32'h3, 32'h2000_0000, 32'h2000_0000};
    logic [LW-1:0] ex [3] = '{32'h0, 32'hFFFF_FFFF, 32'h0};
    for (int t = 0; t < 3; t++) begin
      in_d.delete(); in_k.delete();
      in_d.push_back({L{dd[t]}});
      in_k.push_back('1);
      do_start(md[t], st[t], kk[t]);
      run(99, 0, 100, -1, -1, 0);
      n_vec++;
      if (out_d.size() != 1 || out_d[0] !== {L{ex[t]}}) begin
        n_err++;
        $display("FAIL sub_mul case %0d: got %h want %h", t,
                 (out_d.size() > 0) ? out_d[0] : '0, {L{ex[t]}});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_modes_random();
    logic [LW-1:0] kk;
    logic [DW-1:0] exp_d;
    for (int md = 0; md < 8; md++) begin
      for (int st = 0; st < 2; st++) begin
        kk = $urandom_range(1) ? LW'($urandom) : LW'($urandom_range(255));
        fill(3);
        do_start(md, st[0], kk);
        run(99, 20, 70, -1, -1, 0);
        n_vec++;
        if (timed_out || out_d.size() != 3) begin
          n_err++;
          $display("FAIL modes_count m=%0d s=%0d: got %0d want 3", md, st, out_d.size());
        end
        for (int b = 0; b < out_d.size() && b < 3; b++) begin
          exp_d = ref_beat(in_d[b], md, st[0], kk);
          n_vec++;
          if (out_d[b] !== exp_d || out_k[b] !== in_k[b]) begin
            n_err++;
            $display("FAIL modes m=%0d s=%0d beat %0d: got %h want %h",
                     md, st, b, out_d[b], exp_d);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] kk;
    logic [DW-1:0] exp_d;
    kk = LW'($urandom);
    fill(16);
    do_start(ALU_MAX, 1'b0, kk);
    run(99, 20, 50, -1, -1, 0);
    n_vec++;
    if (timed_out || out_d.size() != 16 || done_cnt != 1) begin
      n_err++;
      $display("FAIL bp_count: got %0d beats %0d done want 16/1",
               out_d.size(), done_cnt);
    end
    n_vec++;
    if (stall_viol != 0 || rdy_viol != 0) begin
      n_err++;
      $display("FAIL bp_stable: got stall=%0d ready=%0d want 0/0",
               stall_viol, rdy_viol);
    end
    for (int b = 0; b < out_d.size() && b < 16; b++) begin
      exp_d = ref_beat(in_d[b], ALU_MAX, 1'b0, kk);
      n_vec++;
      if (out_d[b] !== exp_d || out_k[b] !== in_k[b] || out_l[b] !== (b == 15)) begin
        n_err++;
        $display("FAIL bp beat %0d: got %h want %h", b, out_d[b], exp_d);
      end
    end
    @(negedge clk);
    n_vec++;
    if (cnt !== 32'd16) begin
      n_err++;
      $display("FAIL bp_cnt: got %0d want 16", cnt);
    end
  endtask

  task automatic test_latency_bubbles();
    logic [LW-1:0] kk;
    kk = LW'($urandom);
    fill(6);
    do_start(ALU_ADD, 1'b1, kk);
    run(99, 0, 100, 3, -1, 0);
    n_vec++;
    if (out_d.size() != 6 || acc_cyc.size() != 6) begin
      n_err++;
      $display("FAIL lat_count: got %0d out %0d in want 6/6",
               out_d.size(), acc_cyc.size());
    end else begin
      for (int b = 0; b < 6; b++) begin
        n_vec++;
        if (out_cyc[b] - acc_cyc[b] != N ||
            out_d[b] !== ref_beat(in_d[b], ALU_ADD, 1'b1, kk)) begin
          n_err++;
          $display("FAIL latency beat %0d: got %0d cycles want %0d",
                   b, out_cyc[b] - acc_cyc[b], N);
        end
      end
      n_vec++;
      if (acc_cyc[3] - acc_cyc[2] != 3 || out_cyc[3] - out_cyc[2] != 3) begin
        n_err++;
        $display("FAIL bubble_gap: got in=%0d out=%0d want 3/3",
                 acc_cyc[3] - acc_cyc[2], out_cyc[3] - out_cyc[2]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_start_handling();
    logic [LW-1:0] k1, k2;
    logic [DW-1:0] exp_d;
    k1 = LW'($urandom);
    k2 = LW'($urandom);
    fill(5);
    do_start(ALU_ADD, 1'b0, k1);
    run(99, 0, 100, -1, 1, 1);
    n_vec++;
    if (out_d.size() != 5 || done_cnt != 1) begin
      n_err++;
      $display("FAIL start_run1: got %0d beats want 5", out_d.size());
    end
    for (int b = 0; b < out_d.size() && b < 5; b++) begin
      exp_d = ref_beat(in_d[b], ALU_ADD, 1'b0, k1);
      n_vec++;
      if (out_d[b] !== exp_d) begin
        n_err++;
        $display("FAIL start_ignored beat %0d: got %h want %h", b, out_d[b], exp_d);
      end
    end
    @(posedge clk); #1;
    start = 1'b1;
    mode  = ALU_RSUB;
    sat   = 1'b0;
    kin   = k2;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || cnt !== 32'd5) begin
      n_err++;
      $display("FAIL start_at_last: got busy=%b cnt=%0d want 0/5", busy, cnt);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || cnt !== 32'd0) begin
      n_err++;
      $display("FAIL start_after_done: got busy=%b cnt=%0d want 1/0", busy, cnt);
    end
    fill(3);
    run(99, 10, 80, -1, -1, 0);
    for (int b = 0; b < out_d.size() && b < 3; b++) begin
      exp_d = ref_beat(in_d[b], ALU_RSUB, 1'b0, k2);
      n_vec++;
      if (out_d[b] !== exp_d) begin
        n_err++;
        $display("FAIL start_run2 beat %0d: got %h want %h", b, out_d[b], exp_d);
      end
    end
    @(negedge clk);
    n_vec++;
    if (out_d.size() != 3 || cnt !== 32'd3) begin
      n_err++;
      $display("FAIL start_run2_cnt: got %0d/%0d want 3/3", out_d.size(), cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] kk;
    logic [DW-1:0] exp_d;
    kk = LW'($urandom);
    fill(10);
    do_start(ALU_SUB, 1'b1, kk);
    run(5, 0, 100, -1, -1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata} !== '0 ||
        {busy, done, s_if.tready, cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b d=%h busy=%b cnt=%0d want 0",
               m_if.tvalid, m_if.tdata, busy, cnt);
    end
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || m_if.tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_idle: got busy=%b v=%b want 0/0", busy, m_if.tvalid);
    end
    fill(3);
    do_start(ALU_MUL, 1'b1, kk);
    run(99, 0, 100, -1, -1, 0);
    for (int b = 0; b < out_d.size() && b < 3; b++) begin
      exp_d = ref_beat(in_d[b], ALU_MUL, 1'b1, kk);
      n_vec++;
      if (out_d[b] !== exp_d) begin
        n_err++;
        $display("FAIL reset_rerun beat %0d: got %h want %h", b, out_d[b], exp_d);
      end
    end
    @(negedge clk);
    n_vec++;
    if (out_d.size() != 3 || cnt !== 32'd3 || done_cnt != 1) begin
      n_err++;
      $display("FAIL reset_rerun_cnt: got %0d/%0d want 3/3", out_d.size(), cnt);
    end
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    test_reset();
    test_add_wrap_sat();
    test_sub_mul_sat();
    test_modes_random();
    test_backpressure();
    test_latency_bubbles();
    test_start_handling();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
